// File: rtl/shift_pkg.sv
// Shared types and constants for the serial shift receiver/transmitter pair.
// Keeps the FSM encoding and counter sizing in one place for both directions.
package shift_pkg;

  localparam int SHIFT_WIDTH_DEF = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } rx_state_t;

  // Width of the bit counter; at least one bit even for the narrowest word.
  function automatic int cnt_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/shift_rx_if.sv
// Serial-in / parallel-out bundle of the shift receiver.
// The slave modport is the receiver; the master modport is the line driver plus consumer.
interface shift_rx_if #(
  parameter int WIDTH = shift_pkg::SHIFT_WIDTH_DEF
);

  logic             s_en;
  logic             s_in;
  logic             s_start;
  logic [WIDTH-1:0] p_out;
  logic             p_valid;
  logic             p_ready;
  logic             busy;
  logic             overrun;
  logic             clr_ovr;

  modport master (
    output s_en, s_in, s_start, p_ready, clr_ovr,
    input  p_out, p_valid, busy, overrun
  );

  modport slave (
    input  s_en, s_in, s_start, p_ready, clr_ovr,
    output p_out, p_valid, busy, overrun
  );

endinterface

// File: rtl/shift_bit_cnt.sv
// Modulo-WIDTH bit counter shared by the shift receiver and transmitter.
// Clear wins over load-to-1, which wins over increment.
module shift_bit_cnt #(
  parameter int WIDTH = shift_pkg::SHIFT_WIDTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     load_i,
  input  logic                     clr_i,
  input  logic                     inc_i,
  output logic [$clog2(WIDTH)-1:0] cnt_o,
  output logic                     last_o
);

  import shift_pkg::*;

  localparam int CW = $clog2(WIDTH);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= CW'(1);
    end else if (inc_i) begin
      cnt_q <= last_o ? '0 : cnt_q + CW'(1);
    end
  end

  assign last_o = (cnt_q == CW'(WIDTH - 1));
  assign cnt_o  = cnt_q;

endmodule

// File: rtl/shift_rx.sv
// Serial-to-parallel receiver: frames LSB-first words on a start marker and
// hands them to a one-entry valid/ready buffer, flagging dropped words as overrun.
module shift_rx #(
  parameter int WIDTH = shift_pkg::SHIFT_WIDTH_DEF
) (
  input logic       clk,
  input logic       rst_n,
  shift_rx_if.slave rx
);

  import shift_pkg::*;

  rx_state_t                state_q;
  logic [WIDTH-1:0]         shreg_q;
  logic [WIDTH-1:0]         p_out_q;
  logic                     p_valid_q;
  logic                     overrun_q;
  logic [$clog2(WIDTH)-1:0] cnt_unused;
  logic                     last;

  logic             start_bit;
  logic             data_bit;
  logic             complete;
  logic             handshake;
  logic             drop;
  logic [WIDTH-1:0] shreg_d;

  assign start_bit = rx.s_en & rx.s_start;
  assign data_bit  = rx.s_en & ~rx.s_start & (state_q == SHIFT);
  assign complete  = data_bit & last;
  assign handshake = p_valid_q & rx.p_ready;
  assign drop      = complete & p_valid_q & ~rx.p_ready;
  assign shreg_d   = {rx.s_in, shreg_q[WIDTH-1:1]};

  // The raw count only matters to the transmitter; here the last flag suffices.
  shift_bit_cnt #(.WIDTH(WIDTH)) u_bit_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (start_bit),
    .clr_i  (complete),
    .inc_i  (data_bit),
    .cnt_o  (cnt_unused),
    .last_o (last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      p_out_q   <= '0;
      p_valid_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      // A start bit simply keeps shifting: any partial word falls out the bottom.
      if (start_bit || data_bit) begin
        shreg_q <= shreg_d;
      end

      if (start_bit) begin
        state_q <= SHIFT;
      end else if (complete) begin
        state_q <= IDLE;
      end

      if (complete && (!p_valid_q || rx.p_ready)) begin
        p_out_q   <= shreg_d;
        p_valid_q <= 1'b1;
      end else if (handshake) begin
        p_valid_q <= 1'b0;
      end

      if (drop) begin
        overrun_q <= 1'b1;
      end else if (rx.clr_ovr) begin
        overrun_q <= 1'b0;
      end
    end
  end

  assign rx.p_out   = p_out_q;
  assign rx.p_valid = p_valid_q;
  assign rx.busy    = (state_q == SHIFT);
  assign rx.overrun = overrun_q;

endmodule

// File: tb/tb_shift_rx.sv
// Self-checking bench for shift_rx (WIDTH=8): directed table, hand-written
// corner sequences and a randomized phase against a word-level reference model.
module tb_shift_rx;

  localparam int W = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  shift_rx_if #(.WIDTH(W)) rxIf ();

  shift_rx #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rx    (rxIf)
  );

  int assertCount = 0;
  int failCount   = 0;

  // Reference model: bits collected in a queue, words formed arithmetically.
  bit         mCollecting;
  bit         mBits[$];
  logic [7:0] mOut;
  logic       mValid;
  logic       mOvr;

  typedef struct {
    logic [7:0] word;
    int         gap;
    logic [7:0] expOut;
  } vec_t;

  vec_t vecs[4];

  task automatic modelReset();
    mCollecting = 1'b0;
    mBits.delete();
    mOut   = '0;
    mValid = 1'b0;
    mOvr   = 1'b0;
  endtask

  task automatic modelEdge(input logic sEn, input logic sIn, input logic sStart,
                           input logic pReady, input logic clrOvr);
    logic [7:0] w;
    bit         done;
    bit         dropped;
    done    = 1'b0;
    dropped = 1'b0;
    w       = '0;
    if (sEn) begin
      if (sStart) begin
        mBits.delete();
        mBits.push_back(sIn);
        mCollecting = 1'b1;
      end else if (mCollecting) begin
        mBits.push_back(sIn);
        if (mBits.size() == W) begin
          foreach (mBits[k]) w[k] = mBits[k];
          done = 1'b1;
          mCollecting = 1'b0;
          mBits.delete();
        end
      end
    end
    if (done) begin
      if (!mValid || pReady) begin
        mOut   = w;
        mValid = 1'b1;
      end else begin
        dropped = 1'b1;
      end
    end else if (mValid && pReady) begin
      mValid = 1'b0;
    end
    if (dropped) mOvr = 1'b1;
    else if (clrOvr) mOvr = 1'b0;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic checkModel();
    checkOutput("model_p_valid", 32'(rxIf.p_valid), 32'(mValid));
    checkOutput("model_p_out",   32'(rxIf.p_out),   32'(mOut));
    checkOutput("model_busy",    32'(rxIf.busy),    32'(mCollecting));
    checkOutput("model_overrun", 32'(rxIf.overrun), 32'(mOvr));
  endtask

  // Drive one cycle of inputs, advance the model at the edge, sample 1 ns later.
  task automatic applyStimulus(input logic sEn, input logic sIn, input logic sStart,
                               input logic pReady, input logic clrOvr);
    rxIf.s_en    = sEn;
    rxIf.s_in    = sIn;
    rxIf.s_start = sStart;
    rxIf.p_ready = pReady;
    rxIf.clr_ovr = clrOvr;
    @(posedge clk);
    modelEdge(sEn, sIn, sStart, pReady, clrOvr);
    #1;
    checkModel();
  endtask

  task automatic sendWord(input logic [7:0] word, input logic ready, input int gap,
                          input logic clrLast);
    for (int i = 0; i < W; i++) begin
      applyStimulus(1'b1, word[i], (i == 0), ready, (i == W - 1) ? clrLast : 1'b0);
      if (i < W - 1) begin
        checkOutput("busy_mid_word", 32'(rxIf.busy), 32'd1);
        for (int g = 0; g < gap; g++) begin
          applyStimulus(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ready, 1'b0);
        end
      end
    end
  endtask

  initial begin
    logic [7:0] partial;

    vecs[0] = '{word: 8'hA5, gap: 0, expOut: 8'hA5};
    vecs[1] = '{word: 8'h3C, gap: 0, expOut: 8'h3C};
    vecs[2] = '{word: 8'hC3, gap: 0, expOut: 8'hC3};
    vecs[3] = '{word: 8'h81, gap: 2, expOut: 8'h81};

    rxIf.s_en    = 1'b0;
    rxIf.s_in    = 1'b0;
    rxIf.s_start = 1'b0;
    rxIf.p_ready = 1'b0;
    rxIf.clr_ovr = 1'b0;
    modelReset();

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_p_out",   32'(rxIf.p_out),   32'd0);
    checkOutput("reset_p_valid", 32'(rxIf.p_valid), 32'd0);
    checkOutput("reset_busy",    32'(rxIf.busy),    32'd0);
    checkOutput("reset_overrun", 32'(rxIf.overrun), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic, back-to-back and sparse-strobe words, consumer always ready.
    for (int v = 0; v < 4; v++) begin
      sendWord(vecs[v].word, 1'b1, vecs[v].gap, 1'b0);
      checkOutput("vec_p_out",   32'(rxIf.p_out),   32'(vecs[v].expOut));
      checkOutput("vec_p_valid", 32'(rxIf.p_valid), 32'd1);
      checkOutput("vec_busy",    32'(rxIf.busy),    32'd0);
      checkOutput("vec_overrun", 32'(rxIf.overrun), 32'd0);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("valid_one_cycle", 32'(rxIf.p_valid), 32'd0);

    // Overrun with a stalled consumer; set beats a simultaneous clear.
    sendWord(8'h11, 1'b0, 0, 1'b0);
    checkOutput("ovr_first_out", 32'(rxIf.p_out),   32'h11);
    checkOutput("ovr_first_ovr", 32'(rxIf.overrun), 32'd0);
    sendWord(8'h22, 1'b0, 0, 1'b0);
    checkOutput("ovr_keep_out", 32'(rxIf.p_out),   32'h11);
    checkOutput("ovr_set",      32'(rxIf.overrun), 32'd1);
    sendWord(8'h33, 1'b0, 0, 1'b1);
    checkOutput("ovr_set_beats_clr", 32'(rxIf.overrun), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("ovr_cleared", 32'(rxIf.overrun), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("drain_valid", 32'(rxIf.p_valid), 32'd0);
    checkOutput("drain_p_out", 32'(rxIf.p_out),   32'h11);

    // Resync: a partial word abandoned by a fresh start marker.
    partial = 8'hE7;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, partial[i], (i == 0), 1'b1, 1'b0);
    end
    checkOutput("resync_busy",  32'(rxIf.busy),    32'd1);
    checkOutput("resync_valid", 32'(rxIf.p_valid), 32'd0);
    sendWord(8'h5A, 1'b1, 0, 1'b0);
    checkOutput("resync_p_out", 32'(rxIf.p_out),   32'h5A);
    checkOutput("resync_vld",   32'(rxIf.p_valid), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Reset in the middle of a word while a word is pending.
    sendWord(8'h96, 1'b0, 0, 1'b0);
    partial = 8'h0F;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, partial[i], (i == 0), 1'b0, 1'b0);
    end
    checkOutput("prereset_valid", 32'(rxIf.p_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_p_out",   32'(rxIf.p_out),   32'd0);
    checkOutput("midreset_p_valid", 32'(rxIf.p_valid), 32'd0);
    checkOutput("midreset_busy",    32'(rxIf.busy),    32'd0);
    checkOutput("midreset_overrun", 32'(rxIf.overrun), 32'd0);
    modelReset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    sendWord(8'hFF, 1'b1, 0, 1'b0);
    checkOutput("postreset_p_out", 32'(rxIf.p_out),   32'hFF);
    checkOutput("postreset_valid", 32'(rxIf.p_valid), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Randomized traffic against the reference model.
    for (int n = 0; n < 600; n++) begin
      applyStimulus(1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 11) == 0),
                    1'($urandom_range(0, 3) != 0),
                    1'($urandom_range(0, 15) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
